// File: rtl/psr_stack.sv
// psr_stack
// Processor status register with a built-in save/restore LIFO for nested
// interrupt and BRK entry. It also produces a deferred interrupt mask.
//
// Ports:
//   clk          rising-edge clock for all state
//   nrst         asynchronous reset, active-high despite the name
//   db_in        internal data bus
//   db_load      per-bit load enable from db_in
//   zero_load    Z <= NOR of db_in
//   alu_carry    carry from the ALU
//   carry_load   C <= alu_carry
//   alu_overflow overflow from the ALU
//   ovf_load     V <= alu_overflow
//   set_mask     per-bit force to 1
//   clr_mask     per-bit force to 0 (beats set_mask)
//   push         save the current image onto the stack
//   push_brk     BRK value written into the pushed image
//   pop          restore the register from the stack top
//   err_clr      clear the sticky error flags
//   psr_out      visible flags (ONE forced high, BRK forced low)
//   push_image   image a push would store, for a bus write
//   irq_mask     effective interrupt disable
//   depth        number of occupied stack entries
//   full, empty  stack occupancy flags
//   ovf_err      sticky flag: push while full
//   unf_err      sticky flag: pop while empty
module psr_stack #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int C_BIT   = 0,
   parameter int Z_BIT   = 1,
   parameter int I_BIT   = 2,
   parameter int BRK_BIT = 4,
   parameter int ONE_BIT = 5,
   parameter int V_BIT   = 6,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(8'h24)
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic [WIDTH-1:0]             db_in,
   input  logic [WIDTH-1:0]             db_load,
   input  logic                         zero_load,
   input  logic                         alu_carry,
   input  logic                         carry_load,
   input  logic                         alu_overflow,
   input  logic                         ovf_load,
   input  logic [WIDTH-1:0]             set_mask,
   input  logic [WIDTH-1:0]             clr_mask,
   input  logic                         push,
   input  logic                         push_brk,
   input  logic                         pop,
   input  logic                         err_clr,
   output logic [WIDTH-1:0]             psr_out,
   output logic [WIDTH-1:0]             push_image,
   output logic                         irq_mask,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         full,
   output logic                         empty,
   output logic                         ovf_err,
   output logic                         unf_err
);

   localparam int DW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_psr;
   logic [WIDTH-1:0] r_stack [DEPTH];
   logic [DW-1:0]    r_depth;
   logic             r_irq;
   logic             r_ovf;
   logic             r_unf;

   logic [WIDTH-1:0] w_psrOut;
   logic [WIDTH-1:0] w_pushImage;
   logic [WIDTH-1:0] w_updPsr;
   logic [WIDTH-1:0] w_top;
   logic [DW-1:0]    w_wrIdx;
   logic             w_empty;
   logic             w_full;
   logic             w_swap;
   logic             w_popOk;
   logic             w_pushOk;
   logic             w_restore;
   logic             w_stackWr;
   logic             w_ovfSet;
   logic             w_unfSet;

   // The visible image never exposes stored BRK/ONE bits; push_image
   // reinserts the BRK value the control logic wants saved.
   always_comb begin
      w_psrOut          = r_psr;
      w_psrOut[ONE_BIT] = 1'b1;
      w_psrOut[BRK_BIT] = 1'b0;
      w_pushImage          = w_psrOut;
      w_pushImage[BRK_BIT] = push_brk;
   end

   // Stack top selection; a loop compare avoids indexing the array with
   // the wider depth counter.
   always_comb begin
      w_top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_depth == DW'(i + 1)) w_top = r_stack[i];
      end
   end

   // Per-bit source priority, lowest first so later lines override:
   // hold, data bus, dedicated ALU/zero loads, set, then clear.
   always_comb begin
      w_updPsr = r_psr;
      for (int b = 0; b < WIDTH; b++) begin
         if (db_load[b])                   w_updPsr[b] = db_in[b];
         if (b == Z_BIT && zero_load)      w_updPsr[b] = ~|db_in;
         if (b == C_BIT && carry_load)     w_updPsr[b] = alu_carry;
         if (b == V_BIT && ovf_load)       w_updPsr[b] = alu_overflow;
         if (set_mask[b])                  w_updPsr[b] = 1'b1;
         if (clr_mask[b])                  w_updPsr[b] = 1'b0;
      end
   end

   // Stack operation decode. Push together with pop on a non-empty stack
   // is a swap and never errors; on an empty stack it degrades to a plain
   // push, which always fits because DEPTH is at least one.
   always_comb begin
      w_empty   = (r_depth == '0);
      w_full    = (r_depth == DW'(DEPTH));
      w_swap    = push & pop & ~w_empty;
      w_popOk   = pop & ~push & ~w_empty;
      w_pushOk  = push & (pop ? w_empty : ~w_full);
      w_restore = w_swap | w_popOk;
      w_stackWr = w_pushOk | w_swap;
      w_ovfSet  = push & ~pop & w_full;
      w_unfSet  = pop & ~push & w_empty;
      w_wrIdx   = w_swap ? (r_depth - DW'(1)) : r_depth;
   end

   // Flag register and deferred interrupt mask. A restore updates the
   // mask on the same edge (return-from-interrupt); otherwise the mask
   // follows the visible I bit one cycle late.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         r_psr <= RESET_VAL;
         r_irq <= 1'b1;
      end else if (w_restore) begin
         r_psr <= w_top;
         r_irq <= w_top[I_BIT];
      end else begin
         r_psr <= w_updPsr;
         r_irq <= w_psrOut[I_BIT];
      end
   end

   // Stack storage and occupancy. Overflowing pushes are dropped rather
   // than overwriting; depth never wraps.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         r_depth <= '0;
         for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_stackWr && w_wrIdx == DW'(i)) r_stack[i] <= w_pushImage;
         end
         if (w_pushOk)     r_depth <= r_depth + DW'(1);
         else if (w_popOk) r_depth <= r_depth - DW'(1);
      end
   end

   // Sticky errors; a new error on the same edge beats err_clr.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_ovfSet)     r_ovf <= 1'b1;
         else if (err_clr) r_ovf <= 1'b0;
         if (w_unfSet)     r_unf <= 1'b1;
         else if (err_clr) r_unf <= 1'b0;
      end
   end

   assign psr_out    = w_psrOut;
   assign push_image = w_pushImage;
   assign irq_mask   = r_irq;
   assign depth      = r_depth;
   assign full       = w_full;
   assign empty      = w_empty;
   assign ovf_err    = r_ovf;
   assign unf_err    = r_unf;

endmodule

// File: tb/tb_psr_stack.sv
// tb_psr_stack
// Drives directed and random control patterns into psr_stack. A
// byte-and-queue reference model predicts the outputs for each cycle;
// predictions go into a queue and a separate monitor compares them
// against the DUT on the falling edge.
module tb_psr_stack;

   logic       clk = 1'b0;
   logic       nrst;
   logic [7:0] db_in, db_load, set_mask, clr_mask;
   logic       zero_load, alu_carry, carry_load, alu_overflow, ovf_load;
   logic       push, push_brk, pop, err_clr;
   logic [7:0] psr_out, push_image;
   logic       irq_mask;
   logic [2:0] depth;
   logic       full, empty, ovf_err, unf_err;

   typedef struct packed {
      logic [7:0] dbIn, dbLoad, setMask, clrMask;
      logic zeroLoad, aluCarry, carryLoad, aluOvf, ovfLoad;
      logic push, pushBrk, pop, errClr, rst;
   } stim_t;

   typedef struct packed {
      logic [7:0] psrOut, pushImage;
      logic       irq;
      logic [2:0] depth;
      logic       full, empty, ovf, unf;
   } snap_t;

   snap_t      expQ[$];
   logic [7:0] mStk[$];
   logic [7:0] mPsr;
   logic       mIrq, mOvf, mUnf;
   int         nAssert = 0;
   int         nFail   = 0;

   always #5 clk = ~clk;

   psr_stack dut (
      .clk(clk), .nrst(nrst), .db_in(db_in), .db_load(db_load),
      .zero_load(zero_load), .alu_carry(alu_carry), .carry_load(carry_load),
      .alu_overflow(alu_overflow), .ovf_load(ovf_load),
      .set_mask(set_mask), .clr_mask(clr_mask), .push(push),
      .push_brk(push_brk), .pop(pop), .err_clr(err_clr),
      .psr_out(psr_out), .push_image(push_image), .irq_mask(irq_mask),
      .depth(depth), .full(full), .empty(empty),
      .ovf_err(ovf_err), .unf_err(unf_err)
   );

   // Visible flags: ONE always high, BRK always low.
   function automatic logic [7:0] vis(input logic [7:0] r);
      return (r | 8'h20) & 8'hEF;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   task automatic modelReset();
      mPsr = 8'h24;
      mStk.delete();
      mIrq = 1'b1;
      mOvf = 1'b0;
      mUnf = 1'b0;
   endtask

   // Reference behaviour for one clock edge.
   task automatic modelStep(input stim_t s);
      logic [7:0] cur, upd, img, top;
      logic       nIrq, ovfSet, unfSet;
      int         n;
      cur    = vis(mPsr);
      img    = s.pushBrk ? (cur | 8'h10) : cur;
      upd    = (mPsr & ~s.dbLoad) | (s.dbIn & s.dbLoad);
      if (s.zeroLoad)  upd[1] = (s.dbIn == 8'h00);
      if (s.carryLoad) upd[0] = s.aluCarry;
      if (s.ovfLoad)   upd[6] = s.aluOvf;
      upd    = (upd | s.setMask) & ~s.clrMask;
      nIrq   = cur[2];
      ovfSet = 1'b0;
      unfSet = 1'b0;
      n      = mStk.size();
      if (s.push && s.pop && n > 0) begin
         top         = mStk[n-1];
         mStk[n-1]   = img;
         mPsr        = top;
         nIrq        = top[2];
      end else if (s.pop && !s.push) begin
         if (n == 0) begin
            mPsr   = upd;
            unfSet = 1'b1;
         end else begin
            top  = mStk.pop_back();
            mPsr = top;
            nIrq = top[2];
         end
      end else begin
         mPsr = upd;
         if (s.push) begin
            if (n == 4) ovfSet = 1'b1;
            else        mStk.push_back(img);
         end
      end
      mIrq = nIrq;
      mOvf = ovfSet ? 1'b1 : (s.errClr ? 1'b0 : mOvf);
      mUnf = unfSet ? 1'b1 : (s.errClr ? 1'b0 : mUnf);
   endtask

   // Drives one cycle of controls (called just after a rising edge),
   // queues the outputs expected before the next edge, then advances
   // the model across that edge.
   task automatic applyStimulus(input stim_t s);
      snap_t e;
      nrst         = s.rst;
      db_in        = s.dbIn;
      db_load      = s.dbLoad;
      set_mask     = s.setMask;
      clr_mask     = s.clrMask;
      zero_load    = s.zeroLoad;
      alu_carry    = s.aluCarry;
      carry_load   = s.carryLoad;
      alu_overflow = s.aluOvf;
      ovf_load     = s.ovfLoad;
      push         = s.push;
      push_brk     = s.pushBrk;
      pop          = s.pop;
      err_clr      = s.errClr;
      if (s.rst) modelReset();
      e.psrOut    = vis(mPsr);
      e.pushImage = s.pushBrk ? (vis(mPsr) | 8'h10) : vis(mPsr);
      e.irq       = mIrq;
      e.depth     = 3'(mStk.size());
      e.full      = (mStk.size() == 4);
      e.empty     = (mStk.size() == 0);
      e.ovf       = mOvf;
      e.unf       = mUnf;
      expQ.push_back(e);
      if (!s.rst) modelStep(s);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input snap_t e);
      chk("psr_out",    psr_out,          e.psrOut);
      chk("push_image", push_image,       e.pushImage);
      chk("irq_mask",   {7'd0, irq_mask}, {7'd0, e.irq});
      chk("depth",      {5'd0, depth},    {5'd0, e.depth});
      chk("full",       {7'd0, full},     {7'd0, e.full});
      chk("empty",      {7'd0, empty},    {7'd0, e.empty});
      chk("ovf_err",    {7'd0, ovf_err},  {7'd0, e.ovf});
      chk("unf_err",    {7'd0, unf_err},  {7'd0, e.unf});
   endtask

   // Monitor: compares whatever prediction is pending at each falling edge.
   initial begin
      snap_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Stimulus: directed scenarios first, then random traffic.
   initial begin
      stim_t s;
      logic [7:0] imgs [5];
      imgs[0] = 8'hC1; imgs[1] = 8'h82; imgs[2] = 8'h43;
      imgs[3] = 8'h04; imgs[4] = 8'hC5;
      nrst = 1'b1;
      db_in = '0; db_load = '0; set_mask = '0; clr_mask = '0;
      zero_load = 0; alu_carry = 0; carry_load = 0; alu_overflow = 0;
      ovf_load = 0; push = 0; push_brk = 0; pop = 0; err_clr = 0;
      modelReset();
      @(posedge clk);
      #1;

      s = idle(); s.rst = 1'b1; applyStimulus(s);
      s = idle(); applyStimulus(s);

      // Source priority scenario, expected to give 8'h62.
      s = idle(); s.dbIn = 8'h00; s.dbLoad = 8'hFF; s.zeroLoad = 1;
      s.carryLoad = 1; s.aluCarry = 1; s.setMask = 8'h40; s.clrMask = 8'h01;
      applyStimulus(s);
      s = idle(); applyStimulus(s);

      // Push with BRK, clobber, pop back.
      s = idle(); s.dbLoad = 8'hFF; s.dbIn = 8'hE3; applyStimulus(s);
      s = idle(); s.push = 1; s.pushBrk = 1; applyStimulus(s);
      s = idle(); s.dbLoad = 8'hFF; s.dbIn = 8'h00; applyStimulus(s);
      s = idle(); s.pop = 1; applyStimulus(s);
      s = idle(); applyStimulus(s);

      // Deferred I flag on set and clear.
      s = idle(); s.setMask = 8'h04; applyStimulus(s);
      s = idle(); applyStimulus(s);
      s = idle(); applyStimulus(s);
      s = idle(); s.clrMask = 8'h04; applyStimulus(s);
      s = idle(); applyStimulus(s);
      s = idle(); applyStimulus(s);

      // Fill past capacity, drain past empty, clear errors.
      for (int i = 0; i < 5; i++) begin
         s = idle(); s.push = 1; s.pushBrk = i[0];
         s.dbLoad = 8'hFF; s.dbIn = imgs[i];
         applyStimulus(s);
      end
      for (int i = 0; i < 5; i++) begin
         s = idle(); s.pop = 1; applyStimulus(s);
      end
      s = idle(); s.errClr = 1; applyStimulus(s);
      s = idle(); applyStimulus(s);

      // Swap on a two-deep stack, then push+pop on an empty stack.
      s = idle(); s.dbLoad = 8'hFF; s.dbIn = 8'h30; applyStimulus(s);
      s = idle(); s.push = 1; s.dbLoad = 8'hFF; s.dbIn = 8'h21; applyStimulus(s);
      s = idle(); s.push = 1; s.dbLoad = 8'hFF; s.dbIn = 8'hA5; applyStimulus(s);
      s = idle(); s.push = 1; s.pop = 1; s.pushBrk = 1; applyStimulus(s);
      s = idle(); s.pop = 1; applyStimulus(s);
      s = idle(); s.pop = 1; applyStimulus(s);
      s = idle(); s.pop = 1; applyStimulus(s);
      s = idle(); s.errClr = 1; applyStimulus(s);
      s = idle(); s.push = 1; s.pop = 1; applyStimulus(s);
      s = idle(); applyStimulus(s);

      // Random traffic, including occasional mid-run resets.
      for (int i = 0; i < 400; i++) begin
         s = idle();
         s.dbIn      = 8'($urandom);
         s.dbLoad    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom & $urandom);
         s.setMask   = 8'($urandom & $urandom & $urandom);
         s.clrMask   = 8'($urandom & $urandom & $urandom);
         s.zeroLoad  = 1'($urandom_range(0, 1));
         s.aluCarry  = 1'($urandom_range(0, 1));
         s.carryLoad = 1'($urandom_range(0, 1));
         s.aluOvf    = 1'($urandom_range(0, 1));
         s.ovfLoad   = 1'($urandom_range(0, 1));
         s.push      = ($urandom_range(0, 2) == 0);
         s.pushBrk   = 1'($urandom_range(0, 1));
         s.pop       = ($urandom_range(0, 2) == 0);
         s.errClr    = ($urandom_range(0, 9) == 0);
         s.rst       = ($urandom_range(0, 149) == 0);
         applyStimulus(s);
      end

      for (int k = 0; k < 20 && expQ.size() > 0; k++) @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         nAssert++;
         nFail++;
         $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
